// File: rtl/vrased_mon.sv
// vrased_mon: hardware monitor enforcing VRASED attestation access rules with a held kill reset
`ifndef SMEM_BASE
`define SMEM_BASE 16'hA000
`endif
`ifndef SMEM_SIZE
`define SMEM_SIZE 16'h4000
`endif
`ifndef SKEY_BASE
`define SKEY_BASE 16'h6A00
`endif
`ifndef SKEY_SIZE
`define SKEY_SIZE 16'h0040
`endif
module vrased_mon #(
  parameter int                 NWIN          = 2,
  parameter logic [15:0]        SMEM_BASE     = `SMEM_BASE,
  parameter logic [15:0]        SMEM_SIZE     = `SMEM_SIZE,
  parameter logic [15:0]        KMEM_BASE     = `SKEY_BASE,
  parameter logic [15:0]        KMEM_SIZE     = `SKEY_SIZE,
  parameter logic [15:0]        SDATA_BASE    = 16'h0400,
  parameter logic [15:0]        SDATA_SIZE    = 16'h0C00,
  parameter logic [16*NWIN-1:0] WIN_BASE      = {16'h0270, 16'h0230},
  parameter logic [16*NWIN-1:0] WIN_SIZE      = {16'h001F, 16'h0020},
  parameter logic [15:0]        RESET_HANDLER = 16'h0000,
  parameter int                 HOLD_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        puc_rst,
  input  logic [15:0] pc,
  input  logic [15:0] data_addr,
  input  logic [15:0] dma_addr,
  input  logic        data_en,
  input  logic        data_wr,
  input  logic        dma_en,
  input  logic        irq,
  output logic        reset,
  output logic [5:0]  viol_cause,
  output logic [7:0]  viol_cnt,
  output logic [1:0]  state
);
  typedef enum logic [1:0] {IDLE = 2'd0, ATT = 2'd1, KILL = 2'd2} state_t;
  localparam logic [15:0] SMEM_LAST = SMEM_BASE + SMEM_SIZE - 16'd2;
  localparam logic [7:0]  HOLD_INIT = 8'(HOLD_CYCLES - 1);
  function automatic logic hit(input logic [15:0] a, input logic [15:0] b, input logic [15:0] s);
    return (a >= b) && (a <= b + s - 16'd1);
  endfunction
  state_t      state_q, state_d;
  logic        reset_q, reset_d;
  logic [5:0]  viol_cause_q, viol_cause_d, cause;
  logic [7:0]  viol_cnt_q, viol_cnt_d, hold_q, hold_d;
  logic [15:0] prev_pc_q;
  logic        win_data, win_dma, idle, att, viol, pc_smem;
  assign idle    = state_q == IDLE;
  assign att     = state_q == ATT;
  assign pc_smem = hit(pc, SMEM_BASE, SMEM_SIZE);
  // address hits against every output window, for CPU data and DMA
  always_comb begin
    win_data = 1'b0;
    win_dma  = 1'b0;
    for (int i = 0; i < NWIN; i++) begin
      win_data = win_data | hit(data_addr, WIN_BASE[16*i+:16], WIN_SIZE[16*i+:16]);
      win_dma  = win_dma  | hit(dma_addr,  WIN_BASE[16*i+:16], WIN_SIZE[16*i+:16]);
    end
  end
  // all violation causes in parallel; none has priority over another
  always_comb begin
    cause[0] = idle && pc_smem && pc != SMEM_BASE;
    cause[1] = att && !pc_smem && prev_pc_q != SMEM_LAST;
    cause[2] = !att && data_en && hit(data_addr, KMEM_BASE, KMEM_SIZE);
    cause[3] = data_en && data_wr && (idle ? (hit(data_addr, SDATA_BASE, SDATA_SIZE) || win_data)
                                           : att && !hit(data_addr, SDATA_BASE, SDATA_SIZE) && !win_data);
    cause[4] = att && irq;
    cause[5] = dma_en && (att || win_dma || hit(dma_addr, KMEM_BASE, KMEM_SIZE) ||
                          hit(dma_addr, SMEM_BASE, SMEM_SIZE) || hit(dma_addr, SDATA_BASE, SDATA_SIZE));
    viol     = (idle || att) && |cause;
  end
  // next-state: a violation pre-empts any legal transition; KILL holds until the counter drains and pc reaches the handler
  always_comb begin
    state_d      = state_q;
    reset_d      = reset_q;
    viol_cause_d = viol_cause_q;
    viol_cnt_d   = viol_cnt_q;
    hold_d       = hold_q;
    if (viol) begin
      state_d      = KILL;
      reset_d      = 1'b1;
      viol_cause_d = cause;
      viol_cnt_d   = viol_cnt_q == 8'hFF ? viol_cnt_q : viol_cnt_q + 8'd1;
      hold_d       = HOLD_INIT;
    end else begin
      case (state_q)
        IDLE: state_d = pc == SMEM_BASE ? ATT : IDLE;
        ATT:  state_d = pc_smem ? ATT : IDLE;
        KILL: begin
          state_d = (hold_q == 8'd0 && pc == RESET_HANDLER) ? IDLE : KILL;
          reset_d = !(hold_q == 8'd0 && pc == RESET_HANDLER);
          hold_d  = hold_q == 8'd0 ? 8'd0 : hold_q - 8'd1;
        end
        default: begin
          state_d = KILL;
          reset_d = 1'b1;
        end
      endcase
    end
  end
  // state registers with asynchronous power-up clear
  always_ff @(posedge clk or posedge puc_rst) begin
    if (puc_rst) begin
      state_q      <= IDLE;
      reset_q      <= 1'b0;
      viol_cause_q <= 6'd0;
      viol_cnt_q   <= 8'd0;
      hold_q       <= 8'd0;
      prev_pc_q    <= 16'd0;
    end else begin
      state_q      <= state_d;
      reset_q      <= reset_d;
      viol_cause_q <= viol_cause_d;
      viol_cnt_q   <= viol_cnt_d;
      hold_q       <= hold_d;
      prev_pc_q    <= pc;
    end
  end
  assign reset      = reset_q;
  assign viol_cause = viol_cause_q;
  assign viol_cnt   = viol_cnt_q;
  assign state      = state_q;
endmodule

// File: tb/tb_vrased_mon.sv
// tb_vrased_mon: directed self-checking bench for vrased_mon
module tb_vrased_mon;
  logic        clk = 1'b0;
  logic        puc_rst = 1'b1;
  logic [15:0] pc = 16'hE000, data_addr = 16'h0, dma_addr = 16'h0;
  logic        data_en = 1'b0, data_wr = 1'b0, dma_en = 1'b0, irq = 1'b0;
  logic        reset;
  logic [5:0]  viol_cause;
  logic [7:0]  viol_cnt;
  logic [1:0]  state;
  int total = 0, bad = 0;
  vrased_mon dut (
    .clk(clk), .puc_rst(puc_rst), .pc(pc), .data_addr(data_addr), .dma_addr(dma_addr),
    .data_en(data_en), .data_wr(data_wr), .dma_en(dma_en), .irq(irq),
    .reset(reset), .viol_cause(viol_cause), .viol_cnt(viol_cnt), .state(state)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic quiet();
    data_en = 1'b0;
    data_wr = 1'b0;
    dma_en  = 1'b0;
    irq     = 1'b0;
  endtask
  task automatic recover();
    quiet();
    pc = 16'h0000;
    repeat (4) step();
    pc = 16'hE000;
  endtask
  initial begin
    repeat (2) step();
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_reset", 16'(reset), 16'd0);
    chk("rst_cause", 16'(viol_cause), 16'd0);
    chk("rst_cnt", 16'(viol_cnt), 16'd0);
    puc_rst = 1'b0;
    step();
    pc = 16'hA000; step(); chk("legal_enter", 16'(state), 16'd1);
    pc = 16'hA002; step(); chk("legal_mid", 16'(state), 16'd1);
    pc = 16'hDFFE; step(); chk("legal_last", 16'(state), 16'd1);
    pc = 16'hE000; step(); chk("legal_exit", 16'(state), 16'd0);
    chk("legal_reset", 16'(reset), 16'd0);
    chk("legal_cnt", 16'(viol_cnt), 16'd0);
    data_en = 1'b1; data_addr = 16'h6A00; step();
    chk("key_reset", 16'(reset), 16'd1);
    chk("key_state", 16'(state), 16'd2);
    chk("key_cause", 16'(viol_cause), 16'h04);
    chk("key_cnt", 16'(viol_cnt), 16'd1);
    quiet(); pc = 16'h0000;
    repeat (3) step();
    chk("key_hold4", 16'(reset), 16'd1);
    step();
    chk("key_release_state", 16'(state), 16'd0);
    chk("key_release_reset", 16'(reset), 16'd0);
    chk("key_cause_sticky", 16'(viol_cause), 16'h04);
    pc = 16'hA002; irq = 1'b1; step();
    chk("entry_cause", 16'(viol_cause), 16'h01);
    chk("entry_cnt", 16'(viol_cnt), 16'd2);
    quiet(); pc = 16'hE000;
    repeat (4) step();
    chk("kill_stuck_state", 16'(state), 16'd2);
    chk("kill_stuck_reset", 16'(reset), 16'd1);
    pc = 16'h0000; step();
    chk("kill_stuck_exit", 16'(state), 16'd0);
    pc = 16'hA000; step();
    irq = 1'b1; dma_en = 1'b1; dma_addr = 16'hF000; pc = 16'hA002; step();
    chk("atom_dma_cause", 16'(viol_cause), 16'h30);
    chk("atom_dma_cnt", 16'(viol_cnt), 16'd3);
    data_en = 1'b1; data_addr = 16'h6A00; repeat (2) step();
    chk("kill_ignore_cnt", 16'(viol_cnt), 16'd3);
    chk("kill_ignore_cause", 16'(viol_cause), 16'h30);
    quiet(); pc = 16'h0000; repeat (2) step();
    chk("atom_recover", 16'(state), 16'd0);
    pc = 16'hE000; step();
    pc = 16'hA000; step();
    pc = 16'hA004; step();
    pc = 16'hE000; step();
    chk("bad_exit_cause", 16'(viol_cause), 16'h02);
    chk("bad_exit_cnt", 16'(viol_cnt), 16'd4);
    recover(); chk("bad_exit_recover", 16'(state), 16'd0);
    data_en = 1'b1; data_wr = 1'b1; data_addr = 16'h0250; step();
    chk("win_gap_ok", 16'(state), 16'd0);
    data_addr = 16'h024F; step();
    chk("win_edge_cause", 16'(viol_cause), 16'h08);
    chk("win_edge_cnt", 16'(viol_cnt), 16'd5);
    recover();
    pc = 16'hA000; step();
    data_en = 1'b1; data_wr = 1'b1; data_addr = 16'h0FFF; pc = 16'hA002; step();
    chk("att_sdata_ok", 16'(state), 16'd1);
    data_addr = 16'h1000; pc = 16'hA004; step();
    chk("att_wr_cause", 16'(viol_cause), 16'h08);
    chk("att_wr_cnt", 16'(viol_cnt), 16'd6);
    recover();
    dma_en = 1'b1; dma_addr = 16'hE000; step();
    chk("dma_idle_ok", 16'(state), 16'd0);
    dma_addr = 16'hA000; step();
    chk("dma_smem_cause", 16'(viol_cause), 16'h20);
    chk("dma_smem_cnt", 16'(viol_cnt), 16'd7);
    recover();
    pc = 16'hA000; step();
    pc = 16'hDFFE; step();
    pc = 16'hE000; irq = 1'b1; step();
    chk("preempt_state", 16'(state), 16'd2);
    chk("preempt_cause", 16'(viol_cause), 16'h10);
    chk("preempt_cnt", 16'(viol_cnt), 16'd8);
    recover();
    for (int i = 0; i < 248; i++) begin
      data_en = 1'b1; data_addr = 16'h6A3F; step();
      if (i != 247) recover();
    end
    chk("sat_cnt", 16'(viol_cnt), 16'h00FF);
    chk("sat_state", 16'(state), 16'd2);
    quiet();
    #1 puc_rst = 1'b1;
    #1;
    chk("async_reset", 16'(reset), 16'd0);
    chk("async_state", 16'(state), 16'd0);
    chk("async_cnt", 16'(viol_cnt), 16'd0);
    chk("async_cause", 16'(viol_cause), 16'd0);
    step();
    puc_rst = 1'b0; pc = 16'hE000; step();
    chk("post_rst_idle", 16'(state), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vrased_mon.md
VRASED_MON -- requirements
Module: vrased_mon

Interface
REQ-001 SHALL have parameter NWIN, default 2, meaning number of attestation output windows (HMAC/CTR-style), legal range 1..4.
REQ-002 SHALL have parameters SMEM_BASE/SMEM_SIZE, default `SMEM_BASE/`SMEM_SIZE, meaning the attestation code region.
REQ-003 SHALL have parameters KMEM_BASE/KMEM_SIZE, default `SKEY_BASE/`SKEY_SIZE, meaning the key region.
REQ-004 SHALL have parameters SDATA_BASE/SDATA_SIZE, default 16'h0400/16'h0C00, meaning the attestation stack/data region.
REQ-005 SHALL have parameters WIN_BASE/WIN_SIZE, each 16*NWIN bits, default {16'h0270,16'h0230}/{16'h001F,16'h0020}, meaning packed output windows with window i at bits [16i+15:16i].
REQ-006 SHALL have parameter RESET_HANDLER, default 16'h0000, meaning the PC that releases the kill state.
REQ-007 SHALL have parameter HOLD_CYCLES, default 4, meaning the minimum reset assertion length, range 1..255.
REQ-008 SHALL have port clk, input, 1 bit, meaning the system clock.
REQ-009 SHALL have port puc_rst, input, 1 bit, meaning asynchronous active-high reset.
REQ-010 SHALL have ports pc, data_addr and dma_addr, each input, 16 bits, meaning the CPU PC, CPU data address and DMA address.
REQ-011 SHALL have ports data_en, data_wr, dma_en and irq, each input, 1 bit, meaning CPU access, CPU write, DMA access and interrupt.
REQ-012 SHALL have port reset, output, 1 bit, meaning the registered violation reset request.
REQ-013 SHALL have port viol_cause, output, 6 bits, meaning the sticky cause of the last violation.
REQ-014 SHALL have port viol_cnt, output, 8 bits, meaning the saturating violation count.
REQ-015 SHALL have port state, output, 2 bits, meaning the FSM state.

Function
REQ-016 A region hit SHALL mean BASE <= addr <= BASE+SIZE-1, compared as unsigned 16-bit values; SMEM_LAST SHALL equal SMEM_BASE+SMEM_SIZE-2.
REQ-017 The FSM SHALL have states IDLE=0, ATT=1 and KILL=2; encoding 3 SHALL be unreachable and SHALL recover to KILL on the next clock.
REQ-018 IDLE->ATT SHALL occur when pc==SMEM_BASE; pc in SMEM at any other address in IDLE SHALL be violation cause bit0 (illegal entry).
REQ-019 ATT->IDLE SHALL occur when pc leaves SMEM and the previous-cycle pc==SMEM_LAST (registered prev_pc); any other exit SHALL be cause bit1 (illegal exit).
REQ-020 data_en with data_addr in KMEM while the state is not ATT SHALL be cause bit2 (key access).
REQ-021 data_en&data_wr in state IDLE to SDATA or to any window SHALL be cause bit3; in state ATT, such a write outside SDATA and outside all windows SHALL also be cause bit3 (stack/output integrity).
REQ-022 irq==1 in state ATT SHALL be cause bit4 (atomicity).
REQ-023 dma_en in any state with dma_addr in KMEM, SMEM, SDATA or any window, or dma_en in state ATT at any address, SHALL be cause bit5 (DMA).
REQ-024 Violations SHALL be evaluated combinationally each cycle in IDLE and ATT; any violation SHALL move to KILL on the next edge with reset=1 that same edge (1-cycle latency).
REQ-025 On entry to KILL, viol_cause SHALL load the OR of all causes active that cycle, replacing any older value.
REQ-026 On entry to KILL, viol_cnt SHALL increment by 1, saturating at 8'hFF.
REQ-027 On entry to KILL, the hold counter SHALL load HOLD_CYCLES-1.
REQ-028 In KILL, reset SHALL stay 1, the hold counter SHALL decrement to 0, and new violations SHALL be ignored (no count, no cause update).
REQ-029 KILL->IDLE SHALL occur when the hold counter==0 and pc==RESET_HANDLER; reset SHALL drop that same edge, so minimum assertion is HOLD_CYCLES cycles.
REQ-030 When the hold counter==0 and pc!=RESET_HANDLER, the block SHALL remain in KILL indefinitely.
REQ-031 Violation priority SHALL NOT exist; simultaneous causes SHALL all be recorded, and a violation SHALL pre-empt a legal ATT/IDLE transition in the same cycle.
REQ-032 viol_cause SHALL remain stable after leaving KILL until the next violation.

Reset
REQ-033 puc_rst=1 SHALL asynchronously set state=IDLE, reset=0, viol_cause=0, viol_cnt=0, hold counter=0 and prev_pc=0.
REQ-034 Assertion of puc_rst mid-ATT or mid-KILL SHALL abort the operation with no residual state.
REQ-035 Release of puc_rst SHALL be synchronous to clk edges only.

Verification
REQ-036 Legal run: pc=SMEM_BASE, step to SMEM_LAST, exit to 16'hE000 -> states IDLE->ATT->IDLE, reset never 1, viol_cnt=0.
REQ-037 Key read in IDLE: data_en=1, data_addr=KMEM_BASE -> next cycle reset=1, viol_cause=6'b000100, viol_cnt=1; reset held 4 cycles; pc=RESET_HANDLER -> state IDLE.
REQ-038 Jump into SMEM_BASE+2 from IDLE with irq=1 in the same cycle -> viol_cause=6'b000001 (irq ignored outside ATT).
REQ-039 In ATT, irq=1 together with dma_en=1, dma_addr=16'hF000 -> viol_cause=6'b110000; further violations during KILL leave viol_cnt unchanged.
REQ-040 Force 256 violations -> viol_cnt=8'hFF; puc_rst pulse mid-KILL -> reset=0, state=IDLE, viol_cnt=0 immediately without a clock edge.
